// File: rtl/sw_alloc_pkg.sv
// Shared definitions for the 5x5 router switch allocator: port count, index width,
// port-direction encodings and the per-output allocation state.
package sw_alloc_pkg;

   localparam int unsigned NPORT = 5;
   localparam int unsigned PORTW = 3;

   typedef enum logic [2:0] {
      YMINUS = 3'd0,
      XPLUS  = 3'd1,
      YPLUS  = 3'd2,
      XMINUS = 3'd3,
      LOCAL  = 3'd4
   } port_dir_e;

   typedef enum logic {
      OUT_IDLE   = 1'b0,
      OUT_LOCKED = 1'b1
   } out_state_e;

endpackage

// File: rtl/sw_alloc_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after ptr (wrapping) and
// returns it as a one-hot grant plus an any-request flag.
module rr_arb #(
   parameter int unsigned N = 5,
   parameter int unsigned W = 3
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic         any
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   int unsigned idx;

   always_comb begin
      gnt = '0;
      any = 1'b0;
      idx = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!any && req[idx[IW-1:0]]) begin
            gnt[idx[IW-1:0]] = 1'b1;
            any              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sw_alloc.sv
// Wormhole switch allocator: per-output round-robin lock held from head to tail flit,
// driving crossbar selects and per-flit pop/valid handshakes.
module sw_alloc #(
   parameter int unsigned NPORT = sw_alloc_pkg::NPORT,
   parameter int unsigned PORTW = sw_alloc_pkg::PORTW
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [NPORT-1:0]       req,
   input  logic [NPORT*PORTW-1:0] req_port,
   input  logic [NPORT-1:0]       flit_vld,
   input  logic [NPORT-1:0]       flit_tail,
   input  logic [NPORT-1:0]       out_rdy,
   output logic [NPORT-1:0]       in_pop,
   output logic [NPORT-1:0]       out_vld,
   output logic [NPORT*PORTW-1:0] xbar_sel,
   output logic [NPORT-1:0]       grant,
   output logic                   bad_port
);

   import sw_alloc_pkg::*;

   out_state_e       state_q [NPORT];
   out_state_e       state_d [NPORT];
   logic [PORTW-1:0] owner_q [NPORT];
   logic [PORTW-1:0] owner_d [NPORT];
   logic [PORTW-1:0] ptr_q   [NPORT];
   logic [PORTW-1:0] ptr_d   [NPORT];
   logic [NPORT-1:0] grant_q, grant_d;
   logic             bad_q, bad_d;

   logic [PORTW-1:0] rport   [NPORT];
   logic [NPORT-1:0] req_mat [NPORT];
   logic [NPORT-1:0] arb_gnt [NPORT];
   logic [NPORT-1:0] arb_any;
   logic [PORTW-1:0] win     [NPORT];

   function automatic logic [PORTW-1:0] wrap_inc(input logic [PORTW-1:0] p);
      if ({1'b0, p} >= (PORTW+1)'(NPORT - 1)) return '0;
      return p + 1'b1;
   endfunction

   // req_mat[o][i]: input i is free, requests a legal port o, and o is idle
   always_comb begin
      for (int unsigned i = 0; i < NPORT; i++) begin
         rport[i] = req_port[i*PORTW +: PORTW];
      end
      for (int unsigned o = 0; o < NPORT; o++) begin
         req_mat[o] = '0;
         for (int unsigned i = 0; i < NPORT; i++) begin
            if (req[i] && !grant_q[i] && (state_q[o] == OUT_IDLE) &&
                (rport[i] == PORTW'(o)))
               req_mat[o][i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NPORT; g++) begin : g_arb
      rr_arb #(.N(NPORT), .W(PORTW)) u_arb (
         .req (req_mat[g]),
         .ptr (ptr_q[g]),
         .gnt (arb_gnt[g]),
         .any (arb_any[g])
      );
   end

   always_comb begin
      for (int unsigned o = 0; o < NPORT; o++) begin
         win[o] = '0;
         for (int unsigned i = 0; i < NPORT; i++) begin
            if (arb_gnt[o][i]) win[o] = PORTW'(i);
         end
      end
   end

   // Transfers decode purely from registered lock state, so reset clears them at once
   always_comb begin
      in_pop   = '0;
      out_vld  = '0;
      xbar_sel = '0;
      for (int unsigned o = 0; o < NPORT; o++) begin
         if (state_q[o] == OUT_LOCKED) begin
            xbar_sel[o*PORTW +: PORTW] = owner_q[o];
            if (flit_vld[owner_q[o]] && out_rdy[o]) begin
               out_vld[o]          = 1'b1;
               in_pop[owner_q[o]]  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      bad_d   = bad_q;
      for (int unsigned o = 0; o < NPORT; o++) begin
         if (state_q[o] == OUT_IDLE) begin
            if (arb_any[o]) begin
               state_d[o]          = OUT_LOCKED;
               owner_d[o]          = win[o];
               grant_d[win[o]]     = 1'b1;
            end
         end else if (out_vld[o] && flit_tail[owner_q[o]]) begin
            state_d[o]          = OUT_IDLE;
            ptr_d[o]            = wrap_inc(owner_q[o]);
            grant_d[owner_q[o]] = 1'b0;
         end
      end
      for (int unsigned i = 0; i < NPORT; i++) begin
         if (req[i] && ({1'b0, rport[i]} >= (PORTW+1)'(NPORT))) bad_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         for (int unsigned o = 0; o < NPORT; o++) begin
            state_q[o] <= OUT_IDLE;
            owner_q[o] <= '0;
            ptr_q[o]   <= '0;
         end
         grant_q <= '0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         bad_q   <= bad_d;
      end
   end

   assign grant    = grant_q;
   assign bad_port = bad_q;

endmodule
